// File: rtl/branch_tag_allocator_pkg.sv
// Shared sizing for the branch tag allocator and its pointer sub-module.
package branch_tag_allocator_pkg;

    localparam int ADDR   = 32;            // instruction address width
    localparam int W_BRID = 2;             // branch tag width
    localparam int N_BR   = 1 << W_BRID;   // in-flight branches
    localparam int W_CNT  = W_BRID + 1;    // occupancy counter width (0..N_BR)

    // Next ring position; the pointer width makes the wrap implicit.
    function automatic logic [W_BRID-1:0] ring_next(input logic [W_BRID-1:0] ptr);
        return ptr + {{(W_BRID-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/branch_tag_allocator_tag_ring_ptr.sv
// Wrapping tag pointer: load has priority over increment.
module tag_ring_ptr
    import branch_tag_allocator_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              incr,
    input  logic              load,
    input  logic [W_BRID-1:0] load_val,
    output logic [W_BRID-1:0] ptr
);

    logic [W_BRID-1:0] ptr_r;
    logic [W_BRID-1:0] ptr_next_s;

    // Next pointer selection: load, advance, or hold.
    always_comb begin
        ptr_next_s = ptr_r;
        if (load) begin
            ptr_next_s = load_val;
        end else if (incr) begin
            ptr_next_s = ring_next(ptr_r);
        end else begin
            ptr_next_s = ptr_r;
        end
    end

    // Pointer register with synchronous active-low reset to slot 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr_r <= {W_BRID{1'b0}};
        end else begin
            ptr_r <= ptr_next_s;
        end
    end

    assign ptr = ptr_r;

endmodule

// File: rtl/branch_tag_allocator.sv
// Branch tag allocator: circular queue of branch IDs feeding the BTB.
// Tags are granted at the tail and retired in order from the head; a
// mispredicted head collapses the queue so every younger tag is dropped.
module branch_tag_allocator
    import branch_tag_allocator_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              alloc_v_i,
    input  logic [ADDR-1:0]   alloc_pc_i,
    input  logic [ADDR-1:0]   alloc_target_i,
    output logic              alloc_rdy_o,
    output logic [W_BRID-1:0] alloc_id_o,
    input  logic              resolve_v_i,
    input  logic [W_BRID-1:0] resolve_id_i,
    input  logic              mispredict_i,
    output logic              btb_v_o,
    output logic [W_BRID-1:0] btb_pred_id_o,
    output logic [ADDR-1:0]   btb_pc_o,
    output logic [ADDR-1:0]   btb_addr_o,
    output logic [W_BRID-1:0] btb_branch_id_o,
    output logic              flush_o,
    output logic [W_CNT-1:0]  count_o,
    output logic              err_o
);

    localparam logic [W_CNT-1:0] CNT_FULL = W_CNT'(N_BR);
    localparam logic [W_CNT-1:0] CNT_ZERO = {W_CNT{1'b0}};
    localparam logic [W_CNT-1:0] CNT_ONE  = {{(W_CNT-1){1'b0}}, 1'b1};

    logic [W_BRID-1:0] head_s;
    logic [W_BRID-1:0] tail_s;
    logic [W_CNT-1:0]  count_r;
    logic [W_CNT-1:0]  count_next_s;
    logic              btb_v_r;
    logic [W_BRID-1:0] btb_pred_id_r;
    logic [ADDR-1:0]   btb_pc_r;
    logic [ADDR-1:0]   btb_addr_r;
    logic              flush_r;
    logic              err_r;

    logic              alloc_rdy_s;
    logic              resolve_ok_s;
    logic              mispredict_s;
    logic              correct_s;
    logic              alloc_fire_s;
    logic              bad_resolve_s;

    // Readiness comes only from the registered count, so a same-cycle
    // resolve never bypasses a full queue.
    assign alloc_rdy_s   = (count_r != CNT_FULL);
    assign resolve_ok_s  = resolve_v_i & (count_r != CNT_ZERO) & (resolve_id_i == head_s);
    assign mispredict_s  = resolve_ok_s & mispredict_i;
    assign correct_s     = resolve_ok_s & ~mispredict_i;
    assign alloc_fire_s  = alloc_v_i & alloc_rdy_s & ~mispredict_s;
    assign bad_resolve_s = resolve_v_i & ~resolve_ok_s;

    // Head retires one tag on any accepted resolve.
    tag_ring_ptr u_head (
        .clk      (clk),
        .reset    (reset),
        .incr     (resolve_ok_s),
        .load     (1'b0),
        .load_val ({W_BRID{1'b0}}),
        .ptr      (head_s)
    );

    // Tail advances on a grant; a mispredict snaps it just past the head.
    tag_ring_ptr u_tail (
        .clk      (clk),
        .reset    (reset),
        .incr     (alloc_fire_s),
        .load     (mispredict_s),
        .load_val (ring_next(head_s)),
        .ptr      (tail_s)
    );

    // Occupancy update: flush empties, grant/retire adjust by one.
    always_comb begin
        count_next_s = count_r;
        if (mispredict_s) begin
            count_next_s = CNT_ZERO;
        end else begin
            case ({alloc_fire_s, correct_s})
                2'b10:   count_next_s = count_r + CNT_ONE;
                2'b01:   count_next_s = count_r - CNT_ONE;
                default: count_next_s = count_r;
            endcase
        end
    end

    // Control state: count, flush pulse and sticky protocol error.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
            flush_r <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            count_r <= count_next_s;
            flush_r <= mispredict_s;
            err_r   <= err_r | bad_resolve_s;
        end
    end

    // BTB write port: one-cycle registered copy of each granted branch.
    always_ff @(posedge clk) begin
        if (!reset) begin
            btb_v_r       <= 1'b0;
            btb_pred_id_r <= {W_BRID{1'b0}};
            btb_pc_r      <= {ADDR{1'b0}};
            btb_addr_r    <= {ADDR{1'b0}};
        end else begin
            btb_v_r <= alloc_fire_s;
            if (alloc_fire_s) begin
                btb_pred_id_r <= tail_s;
                btb_pc_r      <= alloc_pc_i;
                btb_addr_r    <= alloc_target_i;
            end else begin
                btb_pred_id_r <= btb_pred_id_r;
                btb_pc_r      <= btb_pc_r;
                btb_addr_r    <= btb_addr_r;
            end
        end
    end

    assign alloc_rdy_o     = alloc_rdy_s;
    assign alloc_id_o      = tail_s;
    assign btb_v_o         = btb_v_r;
    assign btb_pred_id_o   = btb_pred_id_r;
    assign btb_pc_o        = btb_pc_r;
    assign btb_addr_o      = btb_addr_r;
    assign btb_branch_id_o = head_s;
    assign flush_o         = flush_r;
    assign count_o         = count_r;
    assign err_o           = err_r;

endmodule

// File: tb/tb_branch_tag_allocator.sv
// Directed self-checking bench for branch_tag_allocator.
module tb_branch_tag_allocator;

    logic        clk;
    logic        reset;
    logic        alloc_v_i;
    logic [31:0] alloc_pc_i;
    logic [31:0] alloc_target_i;
    logic        alloc_rdy_o;
    logic [1:0]  alloc_id_o;
    logic        resolve_v_i;
    logic [1:0]  resolve_id_i;
    logic        mispredict_i;
    logic        btb_v_o;
    logic [1:0]  btb_pred_id_o;
    logic [31:0] btb_pc_o;
    logic [31:0] btb_addr_o;
    logic [1:0]  btb_branch_id_o;
    logic        flush_o;
    logic [2:0]  count_o;
    logic        err_o;

    int total_r;
    int bad_r;

    branch_tag_allocator dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_v_i       (alloc_v_i),
        .alloc_pc_i      (alloc_pc_i),
        .alloc_target_i  (alloc_target_i),
        .alloc_rdy_o     (alloc_rdy_o),
        .alloc_id_o      (alloc_id_o),
        .resolve_v_i     (resolve_v_i),
        .resolve_id_i    (resolve_id_i),
        .mispredict_i    (mispredict_i),
        .btb_v_o         (btb_v_o),
        .btb_pred_id_o   (btb_pred_id_o),
        .btb_pc_o        (btb_pc_o),
        .btb_addr_o      (btb_addr_o),
        .btb_branch_id_o (btb_branch_id_o),
        .flush_o         (flush_o),
        .count_o         (count_o),
        .err_o           (err_o)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_r = total_r + 1;
        if (got !== exp) begin
            bad_r = bad_r + 1;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alloc_v_i    = 1'b0;
        resolve_v_i  = 1'b0;
        mispredict_i = 1'b0;
        resolve_id_i = 2'd0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b0;
        step();
        reset = 1'b1;
    endtask

    task automatic fill4();
        for (int i = 0; i < 4; i++) begin
            alloc_v_i      = 1'b1;
            alloc_pc_i     = 32'h100 + 32'(4 * i);
            alloc_target_i = 32'h2000 + 32'(i);
            step();
            chk("fill_btb_v", {31'd0, btb_v_o}, 32'd1);
            chk("fill_pred_id", {30'd0, btb_pred_id_o}, 32'(i));
            chk("fill_pc", btb_pc_o, 32'h100 + 32'(4 * i));
            chk("fill_target", btb_addr_o, 32'h2000 + 32'(i));
            chk("fill_count", {29'd0, count_o}, 32'(i + 1));
        end
        alloc_v_i = 1'b0;
    endtask

    initial begin
        total_r        = 0;
        bad_r          = 0;
        reset          = 1'b0;
        alloc_pc_i     = 32'd0;
        alloc_target_i = 32'd0;
        idle();
        step();
        do_reset();

        // Reset state.
        chk("rst_count", {29'd0, count_o}, 32'd0);
        chk("rst_rdy", {31'd0, alloc_rdy_o}, 32'd1);
        chk("rst_btb_v", {31'd0, btb_v_o}, 32'd0);
        chk("rst_pred_id", {30'd0, btb_pred_id_o}, 32'd0);
        chk("rst_pc", btb_pc_o, 32'd0);
        chk("rst_flush", {31'd0, flush_o}, 32'd0);
        chk("rst_err", {31'd0, err_o}, 32'd0);
        chk("rst_alloc_id", {30'd0, alloc_id_o}, 32'd0);
        chk("rst_head", {30'd0, btb_branch_id_o}, 32'd0);

        // Fill to full; ready drops.
        fill4();
        chk("full_rdy", {31'd0, alloc_rdy_o}, 32'd0);

        // Alloc against a full queue is refused.
        alloc_v_i = 1'b1;
        alloc_pc_i = 32'h999;
        step();
        chk("full_no_btb_v", {31'd0, btb_v_o}, 32'd0);
        chk("full_count_hold", {29'd0, count_o}, 32'd4);
        alloc_v_i = 1'b0;

        // In-order correct resolves; no bypass of ready in the resolve cycle.
        resolve_v_i = 1'b1;
        resolve_id_i = 2'd0;
        #1;
        chk("no_bypass_rdy", {31'd0, alloc_rdy_o}, 32'd0);
        step();
        chk("res0_head", {30'd0, btb_branch_id_o}, 32'd1);
        chk("res0_count", {29'd0, count_o}, 32'd3);
        chk("res0_rdy", {31'd0, alloc_rdy_o}, 32'd1);
        resolve_id_i = 2'd1;
        step();
        chk("res1_head", {30'd0, btb_branch_id_o}, 32'd2);
        chk("res1_count", {29'd0, count_o}, 32'd2);
        chk("res1_err", {31'd0, err_o}, 32'd0);
        idle();

        // Reset with two outstanding tags.
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk("midrst_count", {29'd0, count_o}, 32'd0);
        chk("midrst_alloc_id", {30'd0, alloc_id_o}, 32'd0);
        chk("midrst_flush", {31'd0, flush_o}, 32'd0);
        chk("midrst_btb_v", {31'd0, btb_v_o}, 32'd0);

        // Three outstanding with head=1, then mispredict with a colliding alloc.
        fill4();
        resolve_v_i = 1'b1;
        resolve_id_i = 2'd0;
        step();
        chk("pre_mp_count", {29'd0, count_o}, 32'd3);
        resolve_id_i   = 2'd1;
        mispredict_i   = 1'b1;
        alloc_v_i      = 1'b1;
        alloc_pc_i     = 32'h500;
        alloc_target_i = 32'h600;
        step();
        chk("mp_flush", {31'd0, flush_o}, 32'd1);
        chk("mp_count", {29'd0, count_o}, 32'd0);
        chk("mp_btb_v", {31'd0, btb_v_o}, 32'd0);
        chk("mp_tail", {30'd0, alloc_id_o}, 32'd2);
        chk("mp_head", {30'd0, btb_branch_id_o}, 32'd2);
        idle();
        step();
        chk("mp_flush_end", {31'd0, flush_o}, 32'd0);
        chk("mp_err_clean", {31'd0, err_o}, 32'd0);

        // Resolve on an empty queue: error, nothing moves.
        resolve_v_i = 1'b1;
        resolve_id_i = 2'd2;
        step();
        chk("empty_err", {31'd0, err_o}, 32'd1);
        chk("empty_count", {29'd0, count_o}, 32'd0);
        chk("empty_head", {30'd0, btb_branch_id_o}, 32'd2);
        chk("empty_tail", {30'd0, alloc_id_o}, 32'd2);
        idle();
        step();
        chk("empty_err_sticky", {31'd0, err_o}, 32'd1);

        // Steady alloc + resolve every cycle; tags wrap, count stays at 1.
        do_reset();
        alloc_v_i = 1'b1;
        alloc_pc_i = 32'h300;
        step();
        chk("steady_pre_count", {29'd0, count_o}, 32'd1);
        for (int k = 0; k < 10; k++) begin
            alloc_v_i    = 1'b1;
            alloc_pc_i   = 32'h304 + 32'(4 * k);
            resolve_v_i  = 1'b1;
            resolve_id_i = 2'(k % 4);
            step();
            chk("steady_count", {29'd0, count_o}, 32'd1);
            chk("steady_btb_v", {31'd0, btb_v_o}, 32'd1);
            chk("steady_pred_id", {30'd0, btb_pred_id_o}, 32'((k + 1) % 4));
            chk("steady_head", {30'd0, btb_branch_id_o}, 32'((k + 1) % 4));
            chk("steady_err", {31'd0, err_o}, 32'd0);
        end
        idle();

        // Wrong id while non-empty (head=2): error, state unchanged.
        resolve_v_i = 1'b1;
        resolve_id_i = 2'd3;
        step();
        chk("wrongid_err", {31'd0, err_o}, 32'd1);
        chk("wrongid_count", {29'd0, count_o}, 32'd1);
        chk("wrongid_head", {30'd0, btb_branch_id_o}, 32'd2);
        chk("wrongid_tail", {30'd0, alloc_id_o}, 32'd3);
        idle();
        step();
        chk("wrongid_sticky", {31'd0, err_o}, 32'd1);

        // Reset clears the sticky error.
        do_reset();
        chk("final_err", {31'd0, err_o}, 32'd0);
        chk("final_count", {29'd0, count_o}, 32'd0);

        $display("test done: total=%0d bad=%0d", total_r, bad_r);
        $finish;
    end

endmodule
